// File: rtl/block_b_tx.sv
//----------------------------------------------------------------------------
// Module      : block_b_tx
// Description : Transmit side for block_b. Buffers upstream words in a FIFO
//               and emits each as a one-cycle data_en strobe, with a
//               programmable idle gap after every strobe.
//               Optional macro BLOCK_B_TX_PARITY_EN adds the data_par output.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module block_b_tx #(
  parameter int DATA_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_W      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [GAP_W-1:0]                   gap_cfg,
  input  logic                               flush,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_en,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill
`ifdef BLOCK_B_TX_PARITY_EN
  ,
  output logic                               data_par
`endif
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(FIFO_DEPTH);
  localparam logic [0:0]        c_st_idle   = 1'b0;
  localparam logic [0:0]        c_st_gap    = 1'b1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [FILL_W-1:0]     r_fill;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_en;
  logic                  w_wr_ready;
  logic                  w_push;
  logic                  w_pop;

  // Ready looks only at occupancy, never at a same-cycle pop.
  assign w_wr_ready = (r_fill != c_fill_full) && !flush;
  assign w_push     = wr_valid && w_wr_ready;
  assign w_pop      = !flush && (r_state == c_st_idle) && (r_fill != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + FILL_W'(1);
      end else if (w_pop && !w_push) begin
        r_fill <= r_fill - FILL_W'(1);
      end
    end
  end

  // Gap is latched at the pop so later gap_cfg changes cannot stretch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_st_idle;
      r_gap_cnt <= '0;
    end else if (flush) begin
      r_state   <= c_st_idle;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_pop) begin
            r_gap_cnt <= gap_cfg;
            r_state   <= (gap_cfg != '0) ? c_st_gap : c_st_idle;
          end
        end
        c_st_gap: begin
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          if (r_gap_cnt <= GAP_W'(1)) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state   <= c_st_idle;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out <= '0;
      r_data_en  <= 1'b0;
    end else begin
      r_data_en <= w_pop;
      if (w_pop) begin
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef BLOCK_B_TX_PARITY_EN
  logic r_data_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_par <= 1'b0;
    end else if (w_pop) begin
      r_data_par <= ^r_mem[r_rd_ptr];
    end
  end

  assign data_par = r_data_par;
`endif

  assign wr_ready = w_wr_ready;
  assign data_out = r_data_out;
  assign data_en  = r_data_en;
  assign fill     = r_fill;
  assign busy     = (r_fill != '0) || (r_state == c_st_gap);

endmodule

`default_nettype wire

// File: tb/tb_block_b_tx.sv
//----------------------------------------------------------------------------
// Module      : tb_block_b_tx
// Description : Directed self-checking bench for block_b_tx.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_block_b_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] wr_data = '0;
  logic [3:0] gap_cfg = '0;
  logic       wr_ready;
  logic       data_en;
  logic       busy;
  logic [4:0] data_out;
  logic [2:0] fill;
`ifdef BLOCK_B_TX_PARITY_EN
  logic       data_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  block_b_tx #(
    .DATA_WIDTH(5),
    .FIFO_DEPTH(4),
    .GAP_W     (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data (wr_data),
    .gap_cfg (gap_cfg),
    .flush   (flush),
    .data_out(data_out),
    .data_en (data_en),
    .busy    (busy),
    .fill    (fill)
`ifdef BLOCK_B_TX_PARITY_EN
    ,
    .data_par(data_par)
`endif
  );

  task automatic test_reset();
    rst = 1'b0; wr_valid = 1'b0; flush = 1'b0; gap_cfg = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data_en, data_out, busy, fill} !== {1'b0, 5'h00, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_held: got en=%b out=%h busy=%b fill=%0d, want 0/00/0/0",
               data_en, data_out, busy, fill);
    end
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if ({data_en, data_out, busy, fill, wr_ready} !== {1'b0, 5'h00, 1'b0, 3'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got en=%b out=%h busy=%b fill=%0d rdy=%b, want 0/00/0/0/1",
                 k, data_en, data_out, busy, fill, wr_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] words [3] = '{5'h0A, 5'h15, 5'h1F};
    logic       e_en   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] e_out  [5] = '{5'h00, 5'h0A, 5'h15, 5'h1F, 5'h1F};
    logic [2:0] e_fill [5] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
    logic       e_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    gap_cfg = 4'd0;
    wr_valid = 1'b1; wr_data = words[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({data_en, data_out, fill, busy} !== {e_en[k], e_out[k], e_fill[k], e_busy[k]}) begin
        n_fail++;
        $display("FAIL b2b c%0d: got en=%b out=%h fill=%0d busy=%b, want en=%b out=%h fill=%0d busy=%b",
                 k + 1, data_en, data_out, fill, busy, e_en[k], e_out[k], e_fill[k], e_busy[k]);
      end
      if (k < 2) wr_data = words[k+1];
      else wr_valid = 1'b0;
    end
  endtask

  task automatic test_gap();
    logic [4:0] exp_out = 5'h1F;
    logic       exp_en;
    logic [2:0] peak = '0;
    gap_cfg = 4'd2;
    wr_valid = 1'b1; wr_data = 5'd1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_en = (k >= 2) && (k <= 11) && (((k - 2) % 3) == 0);
      if (exp_en) exp_out = 5'((k - 2) / 3 + 1);
      if (fill > peak) peak = fill;
      n_checks++;
      if ({data_en, data_out} !== {exp_en, exp_out}) begin
        n_fail++;
        $display("FAIL gap2 c%0d: got en=%b out=%h, want en=%b out=%h",
                 k, data_en, data_out, exp_en, exp_out);
      end
      if (k < 4) wr_data = 5'(k + 1);
      else wr_valid = 1'b0;
    end
    n_checks++;
    if (peak !== 3'd3) begin
      n_fail++;
      $display("FAIL gap2_peak: got fill peak %0d, want 3", peak);
    end
    n_checks++;
    if ({fill, busy} !== {3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL gap2_drain: got fill=%0d busy=%b, want 0/0", fill, busy);
    end
  endtask

  task automatic test_full_backpressure();
    logic [4:0] exp_out = 5'h04;
    logic       exp_en;
    logic       exp_rdy;
    logic       acc;
    int         n_acc = 0;
    gap_cfg = 4'd7;
    wr_valid = 1'b1; wr_data = 5'd1;
    for (int k = 1; k <= 84; k++) begin
      acc = wr_valid && wr_ready;
      @(negedge clk);
      if (acc) n_acc++;
      exp_en  = (k >= 2) && (k <= 74) && (((k - 2) % 8) == 0);
      if (exp_en) exp_out = 5'(3 * ((k - 2) / 8) + 1);
      exp_rdy = !((k >= 5) && (k <= 49) && (((k - 2) % 8) != 0));
      n_checks++;
      if ({data_en, data_out, wr_ready} !== {exp_en, exp_out, exp_rdy}) begin
        n_fail++;
        $display("FAIL gap7_full c%0d: got en=%b out=%h rdy=%b, want en=%b out=%h rdy=%b",
                 k, data_en, data_out, wr_ready, exp_en, exp_out, exp_rdy);
      end
      wr_data  = 5'(3 * n_acc + 1);
      wr_valid = (n_acc < 10);
    end
    n_checks++;
    if (n_acc !== 10) begin
      n_fail++;
      $display("FAIL gap7_accepted: got %0d words accepted, want 10", n_acc);
    end
  endtask

  task automatic test_flush();
    gap_cfg = 4'd7;
    wr_valid = 1'b1; wr_data = 5'h09;
    @(negedge clk); wr_data = 5'h0C;
    @(negedge clk); wr_data = 5'h0E;
    @(negedge clk);
    n_checks++;
    if ({fill, busy, data_out} !== {3'd2, 1'b1, 5'h09}) begin
      n_fail++;
      $display("FAIL flush_pre: got fill=%0d busy=%b out=%h, want 2/1/09", fill, busy, data_out);
    end
    flush = 1'b1; wr_data = 5'h1E;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got wr_ready=%b, want 0", wr_ready);
    end
    @(negedge clk);
    flush = 1'b0; wr_valid = 1'b0;
    n_checks++;
    if ({fill, busy, data_en, data_out} !== {3'd0, 1'b0, 1'b0, 5'h09}) begin
      n_fail++;
      $display("FAIL flush_post: got fill=%0d busy=%b en=%b out=%h, want 0/0/0/09",
               fill, busy, data_en, data_out);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if ({data_en, data_out, fill} !== {1'b0, 5'h09, 3'd0}) begin
        n_fail++;
        $display("FAIL flush_quiet c%0d: got en=%b out=%h fill=%0d, want 0/09/0",
                 k, data_en, data_out, fill);
      end
    end
    gap_cfg = 4'd0;
    wr_valid = 1'b1; wr_data = 5'h11;
    @(negedge clk);
    wr_valid = 1'b0;
    n_checks++;
    if ({data_en, fill} !== {1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL flush_rewrite_lat: got en=%b fill=%0d, want 0/1", data_en, fill);
    end
    @(negedge clk);
    n_checks++;
    if ({data_en, data_out} !== {1'b1, 5'h11}) begin
      n_fail++;
      $display("FAIL flush_rewrite: got en=%b out=%h, want 1/11", data_en, data_out);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    gap_cfg = 4'd7;
    wr_valid = 1'b1; wr_data = 5'h13;
    @(negedge clk); wr_data = 5'h05;
    @(negedge clk); wr_data = 5'h06;
    @(negedge clk); wr_data = 5'h08;
    @(negedge clk);
    wr_valid = 1'b0;
    n_checks++;
    if ({fill, data_out} !== {3'd3, 5'h13}) begin
      n_fail++;
      $display("FAIL arst_pre: got fill=%0d out=%h, want 3/13", fill, data_out);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({data_out, data_en, busy, fill} !== {5'h00, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL arst_async: got out=%h en=%b busy=%b fill=%0d, want 00/0/0/0",
               data_out, data_en, busy, fill);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({data_en, fill, busy, wr_ready} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL arst_after c%0d: got en=%b fill=%0d busy=%b rdy=%b, want 0/0/0/1",
                 k, data_en, fill, busy, wr_ready);
      end
    end
  endtask

`ifdef BLOCK_B_TX_PARITY_EN
  task automatic test_parity();
    n_checks++;
    if (data_par !== 1'b0) begin
      n_fail++;
      $display("FAIL par_reset: got data_par=%b, want 0", data_par);
    end
    gap_cfg = 4'd0;
    wr_valid = 1'b1; wr_data = 5'h07;
    @(negedge clk); wr_data = 5'h03;
    @(negedge clk); wr_valid = 1'b0;
    n_checks++;
    if ({data_en, data_out, data_par} !== {1'b1, 5'h07, 1'b1}) begin
      n_fail++;
      $display("FAIL par_07: got en=%b out=%h par=%b, want 1/07/1", data_en, data_out, data_par);
    end
    @(negedge clk);
    n_checks++;
    if ({data_en, data_out, data_par} !== {1'b1, 5'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL par_03: got en=%b out=%h par=%b, want 1/03/0", data_en, data_out, data_par);
    end
    @(negedge clk);
    n_checks++;
    if ({data_en, data_par} !== {1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL par_hold: got en=%b par=%b, want 0/0", data_en, data_par);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_full_backpressure();
    test_flush();
    test_async_reset();
`ifdef BLOCK_B_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
